pll_phase_ctrl: RTL and testbench
=================================

# pll_phase_ctrl

Parametrised PLL management block for the ECP5 EHXPLLL clocking path, sitting beside the PLL instance in the clock/reset area and running on the PLL reference clock. It sequences the PLL reset, qualifies LOCK with a stability filter and a retry timeout, and executes dynamic phase-shift requests, producing PHASESEL/PHASEDIR/PHASESTEP for up to four output channels. It also tracks the net phase position of every channel.

## Interface
- N_CH, 4: number of steerable outputs, 1..4.
- STEP_W, 8: width of the step-count request field.
- POS_W, 8: width of each per-channel phase-position counter.
- RST_CYC, 16: cycles o_pll_rst is held high per reset attempt (≥1).
- LOCK_FILT, 1024: consecutive cycles of i_pll_lock=1 required before o_locked rises (≥1).
- LOCK_TIMEOUT, 65536: cycles in WAIT_LOCK without qualified lock before a reset retry (>LOCK_FILT).
- SETUP_CYC, 2: cycles PHASESEL/PHASEDIR are stable before the first step pulse (≥1).
- PULSE_CYC, 2: PHASESTEP high time per step (≥1).
- GAP_CYC, 4: PHASESTEP low time after each pulse (≥1).

Ports:
- i_clk, in, 1: PLL reference clock; the only clock.
- i_rst_n, in, 1: reset, synchronous, active-low.
- i_pll_lock, in, 1: raw PLL LOCK (already synchronised to i_clk).
- i_req_valid, in, 1: phase request valid.
- o_req_ready, out, 1: request accepted when valid and ready are both high.
- i_req_ch, in, 2: channel code (0 CLKOS, 1 CLKOS2, 2 CLKOS3, 3 CLKOP).
- i_req_dir, in, 1: 1 = advance, 0 = delay.
- i_req_steps, in, STEP_W: number of steps.
- o_pll_rst, out, 1: PLL RST.
- o_phasesel, out, 2: drives PHASESEL1:0.
- o_phasedir, out, 1: drives PHASEDIR.
- o_phasestep, out, 1: drives PHASESTEP.
- o_locked, out, 1: filtered lock.
- o_busy, out, 1: request in progress (SETUP/STEP_HI/STEP_LO/DONE).
- o_done, out, 1: one-cycle completion pulse.
- o_err, out, 1: sticky error.
- o_phase_pos, out, N_CH*POS_W: per-channel net step count, channel k at bits [k*POS_W +: POS_W].

## Operation
- States: RESET_PLL, WAIT_LOCK, IDLE, SETUP, STEP_HI, STEP_LO, DONE.
- RESET_PLL: o_pll_rst=1 for RST_CYC cycles. Clears all o_phase_pos. Then goes to WAIT_LOCK.
- WAIT_LOCK: the filter counts consecutive i_pll_lock=1 and restarts on any 0.
  - On reaching LOCK_FILT: o_locked=1, go to IDLE.
  - On LOCK_TIMEOUT cycles elapsed in this state: go to RESET_PLL, retries unlimited.
- IDLE: o_req_ready=1.
  - On accept: latch ch, dir and steps, clear o_err, go to SETUP.
  - If i_pll_lock=0: o_locked=0 next cycle, go to WAIT_LOCK.
- SETUP: o_phasesel and o_phasedir driven from the latched values for SETUP_CYC cycles, then STEP_HI.
- STEP_HI: o_phasestep=1 for PULSE_CYC cycles. On leaving, update o_phase_pos[ch] (+1 advance, −1 delay, modulo 2^POS_W) and decrement remaining steps.
- STEP_LO: o_phasestep=0 for GAP_CYC cycles. Then STEP_HI if remaining steps ≠ 0, else DONE.
- DONE: o_done=1 for one cycle, then IDLE.
- steps=0: SETUP runs, then DONE; no pulse is issued.
- ch ≥ N_CH: the request is accepted, o_err is set, and the block goes straight to DONE with no pulse and no position change.
- Lock loss (i_pll_lock=0) in SETUP/STEP_HI/STEP_LO: abort the request.
  - o_phasestep=0 next cycle, o_err=1, o_locked=0, no o_done, go to WAIT_LOCK.
  - A step whose high phase is interrupted is not counted.
- Accept and lock drop in the same cycle: the request is latched and o_err is set, and the next state is WAIT_LOCK.
- o_phasesel/o_phasedir hold their last values outside SETUP/STEP_* states.

## Timing
- Reset values (i_rst_n=0 at an edge):
  - o_pll_rst=1.
  - All other outputs 0; o_phase_pos all 0.
  - State is RESET_PLL with a fresh RST_CYC count starting at the first edge with i_rst_n=1.
- Reset asserted mid-operation: aborts immediately; no o_done.
- All outputs are registered except o_req_ready, which equals (state==IDLE).
- Request accepted at edge T:
  - First o_phasestep=1 cycle is T+1+SETUP_CYC.
  - Each step takes PULSE_CYC+GAP_CYC cycles.
  - o_done is high in cycle T+1+SETUP_CYC+N·(PULSE_CYC+GAP_CYC).
  - o_req_ready is high again the following cycle.
- o_phase_pos updates in the first cycle after each pulse's falling edge.

## Structure
- pll_ctrl_pkg contains:
  - State enum.
  - PHASESEL channel code constants (CH_CLKOS..CH_CLKOP).
  - Direction constants DIR_ADV/DIR_DLY.
- The lock-qualification counter and timeout are a natural sub-module, pll_lock_filter. Its ports are i_clk, i_rst_n, i_clr, i_lock, o_locked and o_timeout.

## Test plan
- Lock held high from reset with LOCK_FILT=8, RST_CYC=4 → o_pll_rst high 4 cycles, then o_locked rises exactly 8 cycles after the lock count starts, then o_req_ready=1.
- Lock never rises with LOCK_TIMEOUT=32 → o_pll_rst re-pulses every 4+32 cycles indefinitely; o_locked stays 0.
- Request ch=3, dir=1, steps=3 with SETUP=2, PULSE=2, GAP=4 → three 2-cycle pulses starting at T+3, o_done at T+21, o_phase_pos[3]=3.
- Request ch=0, dir=0, steps=1 from pos 0 → pos[0]=0xFF (wrap); then steps=0 → o_done at T+3 with no pulse.
- Lock drops during the 2nd pulse of a 5-step request → o_phasestep low next cycle, o_err=1, no o_done, pos incremented by 1 only; after relock, o_err clears on the next accepted request.
- Request ch=2 with N_CH=2 → o_err=1, o_done at T+1, no PHASESTEP activity.

Source files
------------

// File: rtl/pll_ctrl_pkg.sv
// Shared state encoding and PHASESEL/PHASEDIR codes for the ECP5 PLL phase controller.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        IDLE,
        SETUP,
        STEP_HI,
        STEP_LO,
        DONE
    } pll_state_t;

    localparam logic [1:0] CH_CLKOS  = 2'd0;
    localparam logic [1:0] CH_CLKOS2 = 2'd1;
    localparam logic [1:0] CH_CLKOS3 = 2'd2;
    localparam logic [1:0] CH_CLKOP  = 2'd3;

    localparam logic DIR_ADV = 1'b1;
    localparam logic DIR_DLY = 1'b0;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/pll_lock_filter.sv
// LOCK stability filter: strobes o_locked on the LOCK_FILT-th consecutive high sample,
// and o_timeout once LOCK_TIMEOUT cycles have passed since i_clr was released.
module pll_lock_filter #(
    parameter int LOCK_FILT    = 1024,
    parameter int LOCK_TIMEOUT = 65536
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_lock,
    output logic o_locked,
    output logic o_timeout
);

    localparam int LW = $clog2(LOCK_FILT + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);

    logic [LW-1:0] lock_cnt;
    logic [TW-1:0] wait_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            lock_cnt <= '0;
            wait_cnt <= '0;
        end else begin
            lock_cnt <= i_lock ? lock_cnt + LW'(1) : '0;
            wait_cnt <= wait_cnt + TW'(1);
        end
    end

    // Strobes describe the edge being sampled now, so the owner can react on it.
    assign o_locked  = !i_clr && i_lock && (lock_cnt == LW'(LOCK_FILT - 1));
    assign o_timeout = !i_clr && (wait_cnt == TW'(LOCK_TIMEOUT - 1));

endmodule

// File: rtl/pll_phase_ctrl.sv
// EHXPLLL manager: PLL reset sequencing, lock qualification with retry, and
// dynamic phase-step execution with per-channel position tracking.
module pll_phase_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int STEP_W       = 8,
    parameter int POS_W        = 8,
    parameter int RST_CYC      = 16,
    parameter int LOCK_FILT    = 1024,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int SETUP_CYC    = 2,
    parameter int PULSE_CYC    = 2,
    parameter int GAP_CYC      = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_pll_lock,
    input  logic                   i_req_valid,
    output logic                   o_req_ready,
    input  logic [1:0]             i_req_ch,
    input  logic                   i_req_dir,
    input  logic [STEP_W-1:0]      i_req_steps,
    output logic                   o_pll_rst,
    output logic [1:0]             o_phasesel,
    output logic                   o_phasedir,
    output logic                   o_phasestep,
    output logic                   o_locked,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_err,
    output logic [N_CH*POS_W-1:0]  o_phase_pos
);

    localparam int CW = $clog2(max4(RST_CYC, SETUP_CYC, PULSE_CYC, GAP_CYC) + 1);
    localparam logic [CW-1:0] RST_LAST   = CW'(RST_CYC - 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYC - 1);

    pll_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0] ch_q, ch_n;
    logic dir_q, dir_n;
    logic [STEP_W-1:0] left_q, left_n;
    logic [N_CH*POS_W-1:0] pos_q, pos_n;
    logic pll_rst_d, sel_dir_d, step_d, locked_d, busy_d, done_d, err_d;
    logic [1:0] sel_d;
    logic abort_req;
    logic filt_clr, filt_locked, filt_timeout;

    assign filt_clr = (state != WAIT_LOCK);

    pll_lock_filter #(
        .LOCK_FILT    (LOCK_FILT),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) u_lock_filter (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clr     (filt_clr),
        .i_lock    (i_pll_lock),
        .o_locked  (filt_locked),
        .o_timeout (filt_timeout)
    );

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + CW'(1);
        ch_n      = ch_q;
        dir_n     = dir_q;
        left_n    = left_q;
        pos_n     = pos_q;
        locked_d  = o_locked;
        err_d     = o_err;
        sel_d     = o_phasesel;
        sel_dir_d = o_phasedir;
        abort_req = 1'b0;

        case (state)
            RESET_PLL: begin
                if (cnt == RST_LAST) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end
            end
            WAIT_LOCK: begin
                if (filt_locked) begin
                    locked_d = 1'b1;
                    state_n  = IDLE;
                end else if (filt_timeout) begin
                    state_n = RESET_PLL;
                    cnt_n   = '0;
                end
            end
            IDLE: begin
                cnt_n = '0;
                // A request is always latched on accept, even if lock is lost on the same edge.
                if (i_req_valid) begin
                    ch_n   = i_req_ch;
                    dir_n  = i_req_dir;
                    left_n = i_req_steps;
                    err_d  = 1'b0;
                    if (!i_pll_lock) begin
                        err_d    = 1'b1;
                        locked_d = 1'b0;
                        state_n  = WAIT_LOCK;
                    end else if (int'(i_req_ch) >= N_CH) begin
                        err_d   = 1'b1;
                        state_n = DONE;
                    end else begin
                        sel_d     = i_req_ch;
                        sel_dir_d = i_req_dir;
                        state_n   = SETUP;
                    end
                end else if (!i_pll_lock) begin
                    locked_d = 1'b0;
                    state_n  = WAIT_LOCK;
                end
            end
            SETUP: begin
                if (!i_pll_lock) begin
                    abort_req = 1'b1;
                end else if (cnt == SETUP_LAST) begin
                    cnt_n   = '0;
                    state_n = (left_q == '0) ? DONE : STEP_HI;
                end
            end
            STEP_HI: begin
                if (!i_pll_lock) begin
                    abort_req = 1'b1;
                end else if (cnt == PULSE_LAST) begin
                    cnt_n   = '0;
                    state_n = STEP_LO;
                    left_n  = left_q - STEP_W'(1);
                    for (int k = 0; k < N_CH; k++) begin
                        if (ch_q == 2'(k)) begin
                            pos_n[k*POS_W +: POS_W] = (dir_q == DIR_ADV)
                                ? pos_q[k*POS_W +: POS_W] + POS_W'(1)
                                : pos_q[k*POS_W +: POS_W] - POS_W'(1);
                        end
                    end
                end
            end
            STEP_LO: begin
                if (!i_pll_lock) begin
                    abort_req = 1'b1;
                end else if (cnt == GAP_LAST) begin
                    cnt_n   = '0;
                    state_n = (left_q == '0) ? DONE : STEP_HI;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = RESET_PLL;
                cnt_n   = '0;
            end
        endcase

        if (abort_req) begin
            err_d    = 1'b1;
            locked_d = 1'b0;
            state_n  = WAIT_LOCK;
        end

        if (state_n == RESET_PLL) begin
            pos_n = '0;
        end

        pll_rst_d = (state_n == RESET_PLL);
        step_d    = (state_n == STEP_HI);
        done_d    = (state_n == DONE);
        busy_d    = state_n inside {SETUP, STEP_HI, STEP_LO, DONE};
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= RESET_PLL;
            cnt         <= '0;
            ch_q        <= '0;
            dir_q       <= 1'b0;
            left_q      <= '0;
            pos_q       <= '0;
            o_pll_rst   <= 1'b1;
            o_phasesel  <= CH_CLKOS;
            o_phasedir  <= 1'b0;
            o_phasestep <= 1'b0;
            o_locked    <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            ch_q        <= ch_n;
            dir_q       <= dir_n;
            left_q      <= left_n;
            pos_q       <= pos_n;
            o_pll_rst   <= pll_rst_d;
            o_phasesel  <= sel_d;
            o_phasedir  <= sel_dir_d;
            o_phasestep <= step_d;
            o_locked    <= locked_d;
            o_busy      <= busy_d;
            o_done      <= done_d;
            o_err       <= err_d;
        end
    end

    assign o_req_ready = (state == IDLE);
    assign o_phase_pos = pos_q;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Self-checking bench for pll_phase_ctrl: timeline-based reference model plus
// directed scenarios with hand-computed expectations.
module tb_pll_phase_ctrl;

    localparam int N_CH         = 4;
    localparam int STEP_W       = 8;
    localparam int POS_W        = 8;
    localparam int RST_CYC      = 4;
    localparam int LOCK_FILT    = 8;
    localparam int LOCK_TIMEOUT = 32;
    localparam int SETUP_CYC    = 2;
    localparam int PULSE_CYC    = 2;
    localparam int GAP_CYC      = 4;
    localparam int STEP_PERIOD  = PULSE_CYC + GAP_CYC;

    logic clk = 1'b0;
    logic rst_n, pll_lock;
    logic req_valid, req_dir;
    logic [1:0] req_ch;
    logic [STEP_W-1:0] req_steps;
    logic req_ready, pll_rst, phasedir, phasestep, locked, busy, done, err;
    logic [1:0] phasesel;
    logic [N_CH*POS_W-1:0] phase_pos;

    logic req2_valid, req2_dir;
    logic [1:0] req2_ch;
    logic [STEP_W-1:0] req2_steps;
    logic req2_ready, pll_rst2, phasedir2, phasestep2, locked2, busy2, done2, err2;
    logic [1:0] phasesel2;
    logic [2*POS_W-1:0] phase_pos2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pll_phase_ctrl #(
        .N_CH(N_CH), .STEP_W(STEP_W), .POS_W(POS_W), .RST_CYC(RST_CYC),
        .LOCK_FILT(LOCK_FILT), .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .SETUP_CYC(SETUP_CYC), .PULSE_CYC(PULSE_CYC), .GAP_CYC(GAP_CYC)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_pll_lock(pll_lock),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_ch(req_ch),
        .i_req_dir(req_dir), .i_req_steps(req_steps), .o_pll_rst(pll_rst),
        .o_phasesel(phasesel), .o_phasedir(phasedir), .o_phasestep(phasestep),
        .o_locked(locked), .o_busy(busy), .o_done(done), .o_err(err),
        .o_phase_pos(phase_pos)
    );

    pll_phase_ctrl #(
        .N_CH(2), .STEP_W(STEP_W), .POS_W(POS_W), .RST_CYC(RST_CYC),
        .LOCK_FILT(LOCK_FILT), .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .SETUP_CYC(SETUP_CYC), .PULSE_CYC(PULSE_CYC), .GAP_CYC(GAP_CYC)
    ) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_pll_lock(pll_lock),
        .i_req_valid(req2_valid), .o_req_ready(req2_ready), .i_req_ch(req2_ch),
        .i_req_dir(req2_dir), .i_req_steps(req2_steps), .o_pll_rst(pll_rst2),
        .o_phasesel(phasesel2), .o_phasedir(phasedir2), .o_phasestep(phasestep2),
        .o_locked(locked2), .o_busy(busy2), .o_done(done2), .o_err(err2),
        .o_phase_pos(phase_pos2)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int which, input logic v, input logic [1:0] ch,
                                 input logic dir, input logic [STEP_W-1:0] steps);
        if (which == 0) begin
            req_valid = v; req_ch = ch; req_dir = dir; req_steps = steps;
        end else begin
            req2_valid = v; req2_ch = ch; req2_dir = dir; req2_steps = steps;
        end
    endtask

    // Reference model: phases of life plus arithmetic on the offset from the accept edge.
    typedef enum {M_RST, M_WAIT, M_READY, M_REQ} mphase_t;
    mphase_t mph = M_RST;
    int  edge_n = 0;
    int  t0 = 0, run = 0, ta = 0, dend = 0, m_d = 0;
    bit  mbad = 1'b0;
    bit  model_valid = 1'b0;
    logic [1:0] mch;
    logic mdir;
    logic e_pll_rst, e_locked, e_ready, e_step, e_done, e_busy, e_err, e_dir;
    logic [1:0] e_sel;
    logic [POS_W-1:0] e_pos [N_CH];

    always @(posedge clk) begin
        edge_n = edge_n + 1;
        if (!rst_n) begin
            mph = M_RST; t0 = edge_n;
            e_locked = 0; e_err = 0; e_sel = 0; e_dir = 0;
            for (int k = 0; k < N_CH; k++) e_pos[k] = '0;
            model_valid = 1'b1;
        end else begin
            case (mph)
                M_RST: if (edge_n - t0 == RST_CYC) begin mph = M_WAIT; t0 = edge_n; run = 0; end
                M_WAIT: begin
                    run = pll_lock ? run + 1 : 0;
                    if (run == LOCK_FILT) begin
                        e_locked = 1; mph = M_READY;
                    end else if (edge_n - t0 == LOCK_TIMEOUT) begin
                        mph = M_RST; t0 = edge_n;
                        for (int k = 0; k < N_CH; k++) e_pos[k] = '0;
                    end
                end
                M_READY: begin
                    if (req_valid) begin
                        mch = req_ch; mdir = req_dir; e_err = 0;
                        if (!pll_lock) begin
                            e_err = 1; e_locked = 0; mph = M_WAIT; t0 = edge_n; run = 0;
                        end else begin
                            ta = edge_n; mph = M_REQ;
                            mbad = (int'(req_ch) >= N_CH);
                            if (mbad) begin
                                e_err = 1; dend = 0;
                            end else begin
                                e_sel = req_ch; e_dir = req_dir;
                                dend = SETUP_CYC + int'(req_steps) * STEP_PERIOD;
                            end
                        end
                    end else if (!pll_lock) begin
                        e_locked = 0; mph = M_WAIT; t0 = edge_n; run = 0;
                    end
                end
                M_REQ: begin
                    m_d = edge_n - ta;
                    if (m_d - 1 < dend && !pll_lock) begin
                        e_err = 1; e_locked = 0; mph = M_WAIT; t0 = edge_n; run = 0;
                    end else if (m_d == dend + 1) begin
                        mph = M_READY;
                    end else if (!mbad && m_d >= SETUP_CYC && m_d < dend &&
                                 (m_d - SETUP_CYC) % STEP_PERIOD == PULSE_CYC) begin
                        e_pos[mch] = mdir ? e_pos[mch] + 8'd1 : e_pos[mch] - 8'd1;
                    end
                end
                default: mph = M_RST;
            endcase
        end
        e_pll_rst = (mph == M_RST);
        e_ready   = (mph == M_READY);
        e_step = 0; e_done = 0; e_busy = 0;
        if (mph == M_REQ) begin
            m_d = edge_n - ta;
            e_busy = 1;
            e_done = (m_d == dend);
            e_step = !mbad && m_d >= SETUP_CYC && m_d < dend &&
                     ((m_d - SETUP_CYC) % STEP_PERIOD < PULSE_CYC);
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            checkOutput("m_pll_rst", pll_rst, e_pll_rst);
            checkOutput("m_locked", locked, e_locked);
            checkOutput("m_ready", req_ready, e_ready);
            checkOutput("m_step", phasestep, e_step);
            checkOutput("m_done", done, e_done);
            checkOutput("m_busy", busy, e_busy);
            checkOutput("m_err", err, e_err);
            checkOutput("m_sel", phasesel, e_sel);
            checkOutput("m_dir", phasedir, e_dir);
            for (int k = 0; k < N_CH; k++)
                checkOutput($sformatf("m_pos%0d", k), phase_pos[k*POS_W +: POS_W], e_pos[k]);
        end
    end

    task automatic wait_edge(input int e);
        while (edge_n < e) begin @(posedge clk); #1; end
    endtask

    task automatic wait_ready(input int limit, input string what);
        int n = 0;
        while (req_ready !== 1'b1 && n < limit) begin @(posedge clk); #1; n++; end
        checkOutput(what, req_ready, 1);
    endtask

    task automatic accept(input logic [1:0] ch, input logic dir, input logic [STEP_W-1:0] steps,
                          output int t);
        applyStimulus(0, 1'b1, ch, dir, steps);
        @(posedge clk); #1;
        t = edge_n;
        applyStimulus(0, 1'b0, 2'd0, 1'b0, '0);
    endtask

    initial begin
        int r, t;
        rst_n = 1'b0; pll_lock = 1'b0;
        applyStimulus(0, 1'b0, 2'd0, 1'b0, '0);
        applyStimulus(1, 1'b0, 2'd0, 1'b0, '0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_pll_rst", pll_rst, 1);
        checkOutput("rst_locked", locked, 0);
        checkOutput("rst_ready", req_ready, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_pos", phase_pos, 0);

        // Lock never arrives: reset re-pulses every RST_CYC+LOCK_TIMEOUT cycles.
        r = edge_n; rst_n = 1'b1;
        wait_edge(r + 3);  checkOutput("retry_rst_hi", pll_rst, 1);
        wait_edge(r + 4);  checkOutput("retry_rst_lo", pll_rst, 0);
        wait_edge(r + 35); checkOutput("retry_wait_lo", pll_rst, 0);
        wait_edge(r + 36); checkOutput("retry_rst_again", pll_rst, 1);
        wait_edge(r + 39); checkOutput("retry_rst_hold", pll_rst, 1);
        wait_edge(r + 40); checkOutput("retry_rst_fall", pll_rst, 0);
        wait_edge(r + 72); checkOutput("retry_third", pll_rst, 1);
        checkOutput("retry_unlocked", locked, 0);

        // Lock held high from reset.
        rst_n = 1'b0;
        @(posedge clk); #1;
        r = edge_n; rst_n = 1'b1; pll_lock = 1'b1;
        wait_edge(r + 4);  checkOutput("lock_rst_lo", pll_rst, 0);
        wait_edge(r + 11); checkOutput("lock_not_yet", locked, 0);
        wait_edge(r + 12); checkOutput("lock_rise", locked, 1);
        checkOutput("lock_ready", req_ready, 1);

        // Channel beyond N_CH on the 2-channel instance.
        checkOutput("n2_ready", req2_ready, 1);
        applyStimulus(1, 1'b1, 2'd2, 1'b1, 8'd3);
        @(posedge clk); #1;
        t = edge_n;
        applyStimulus(1, 1'b0, 2'd0, 1'b0, '0);
        checkOutput("n2_err", err2, 1);
        checkOutput("n2_done", done2, 1);
        checkOutput("n2_step0", phasestep2, 0);
        wait_edge(t + 1);
        checkOutput("n2_done_end", done2, 0);
        checkOutput("n2_ready_back", req2_ready, 1);
        checkOutput("n2_step1", phasestep2, 0);
        checkOutput("n2_sel_hold", phasesel2, 0);
        checkOutput("n2_pos", phase_pos2, 0);

        // ch=3 advance by 3.
        accept(2'd3, 1'b1, 8'd3, t);
        wait_edge(t + 1);  checkOutput("r1_setup_step", phasestep, 0);
        checkOutput("r1_sel", phasesel, 3);
        wait_edge(t + 2);  checkOutput("r1_first_pulse", phasestep, 1);
        wait_edge(t + 4);  checkOutput("r1_gap", phasestep, 0);
        wait_edge(t + 19); checkOutput("r1_pre_done", done, 0);
        wait_edge(t + 20); checkOutput("r1_done", done, 1);
        checkOutput("r1_pos3", phase_pos[3*POS_W +: POS_W], 8'd3);
        wait_edge(t + 21); checkOutput("r1_ready", req_ready, 1);

        // ch=0 delay by 1 wraps, then a zero-step request.
        accept(2'd0, 1'b0, 8'd1, t);
        wait_edge(t + 8);  checkOutput("r2_done", done, 1);
        checkOutput("r2_pos0_wrap", phase_pos[0 +: POS_W], 8'hFF);
        wait_edge(t + 9);
        accept(2'd0, 1'b0, 8'd0, t);
        wait_edge(t + 1);  checkOutput("r3_no_done", done, 0);
        wait_edge(t + 2);  checkOutput("r3_done", done, 1);
        checkOutput("r3_no_step", phasestep, 0);
        wait_edge(t + 3);  checkOutput("r3_ready", req_ready, 1);

        // Lock lost during the second pulse of a 5-step request.
        accept(2'd1, 1'b1, 8'd5, t);
        wait_edge(t + 8);  checkOutput("r4_pulse2", phasestep, 1);
        pll_lock = 1'b0;
        wait_edge(t + 9);
        checkOutput("r4_step_drop", phasestep, 0);
        checkOutput("r4_err", err, 1);
        checkOutput("r4_unlocked", locked, 0);
        checkOutput("r4_pos1", phase_pos[1*POS_W +: POS_W], 8'd1);
        wait_edge(t + 12);
        pll_lock = 1'b1;
        wait_ready(40, "r4_relock_ready");
        checkOutput("r4_err_sticky", err, 1);
        accept(2'd1, 1'b0, 8'd1, t);
        checkOutput("r5_err_clear", err, 0);
        wait_ready(20, "r5_ready");
        checkOutput("r5_pos1", phase_pos[1*POS_W +: POS_W], 8'd0);

        // Accept and lock drop on the same edge.
        applyStimulus(0, 1'b1, 2'd2, 1'b1, 8'd2);
        pll_lock = 1'b0;
        @(posedge clk); #1;
        applyStimulus(0, 1'b0, 2'd0, 1'b0, '0);
        pll_lock = 1'b1;
        checkOutput("r6_err", err, 1);
        checkOutput("r6_not_ready", req_ready, 0);
        checkOutput("r6_sel_hold", phasesel, 1);
        checkOutput("r6_busy", busy, 0);
        wait_ready(30, "r6_ready");

        // Reset asserted in the middle of a request.
        accept(2'd2, 1'b1, 8'd4, t);
        wait_edge(t + 5);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checkOutput("r7_pll_rst", pll_rst, 1);
        checkOutput("r7_no_done", done, 0);
        checkOutput("r7_step", phasestep, 0);
        checkOutput("r7_pos", phase_pos, 0);
        rst_n = 1'b1;
        wait_ready(30, "r7_ready");

        @(posedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog");
    end

endmodule
